// File: rtl/scan_chain_ctrl.sv
// Sequencer for a two-phase (phi/phib) scan chain: optional capture pair, CHAIN_LEN
// shift bits that serialise tx_data out and collect rx_data back, then an optional load.
module scan_chain_ctrl #(
    parameter int unsigned CHAIN_LEN = 32,
    parameter int unsigned PW        = 2,
    parameter int unsigned GAP       = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 capture_en,
    input  logic                 load_en,
    input  logic [CHAIN_LEN-1:0] tx_data,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rx_data,
    output logic                 phi,
    output logic                 phib,
    output logic                 scan_i0o1,
    output logic                 load,
    output logic                 scan_in,
    input  logic                 scan_out
);

    localparam int unsigned CW   = $clog2(CHAIN_LEN + 1);
    localparam int unsigned TMAX = (PW > GAP) ? PW : GAP;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [3:0] {
        IDLE, CSETUP, CPHI, CGAP1, CPHIB, CGAP2,
        SETUP, PHI, GAP1, PHIB, GAP2,
        LGAP, LOAD, LTAIL, FIN
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CHAIN_LEN-1:0] tx_sr_q, tx_sr_d;
    logic [CHAIN_LEN-1:0] rx_sr_q, rx_sr_d;
    logic                 ld_q, ld_d;

    logic                 phi_q, phi_d;
    logic                 phib_q, phib_d;
    logic                 load_q, load_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sel_q, sel_d;
    logic                 sin_q, sin_d;
    logic [CHAIN_LEN-1:0] rx_data_q, rx_data_d;

    logic pw_last;
    logic gap_last;

    assign pw_last  = (timer_q == TW'(PW - 1));
    assign gap_last = (timer_q == TW'(GAP - 1));

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        count_d = count_q;
        tx_sr_d = tx_sr_q;
        rx_sr_d = rx_sr_q;
        ld_d    = ld_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_sr_d = tx_data;
                    ld_d    = load_en;
                    count_d = '0;
                    state_d = capture_en ? CSETUP : SETUP;
                end
            end
            CSETUP: state_d = CPHI;
            CPHI:   if (pw_last)  state_d = CGAP1; else timer_d = timer_q + TW'(1);
            CGAP1:  if (gap_last) state_d = CPHIB; else timer_d = timer_q + TW'(1);
            CPHIB:  if (pw_last)  state_d = CGAP2; else timer_d = timer_q + TW'(1);
            CGAP2:  if (gap_last) state_d = SETUP; else timer_d = timer_q + TW'(1);
            SETUP: begin
                rx_sr_d = {rx_sr_q[CHAIN_LEN-2:0], scan_out};
                state_d = PHI;
            end
            PHI:    if (pw_last)  state_d = GAP1;  else timer_d = timer_q + TW'(1);
            GAP1:   if (gap_last) state_d = PHIB;  else timer_d = timer_q + TW'(1);
            PHIB:   if (pw_last)  state_d = GAP2;  else timer_d = timer_q + TW'(1);
            GAP2: begin
                if (gap_last) begin
                    tx_sr_d = tx_sr_q << 1;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(CHAIN_LEN - 1)) state_d = ld_q ? LGAP : FIN;
                    else                               state_d = SETUP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LGAP:   if (gap_last) state_d = LOAD;  else timer_d = timer_q + TW'(1);
            LOAD:   if (pw_last)  state_d = LTAIL; else timer_d = timer_q + TW'(1);
            LTAIL:  if (gap_last) state_d = FIN;   else timer_d = timer_q + TW'(1);
            FIN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin is a flop aligned with its state.
    always_comb begin
        phi_d     = (state_d == PHI)  || (state_d == CPHI);
        phib_d    = (state_d == PHIB) || (state_d == CPHIB);
        load_d    = (state_d == LOAD);
        busy_d    = (state_d != IDLE) && (state_d != FIN);
        done_d    = (state_d == FIN);
        sel_d     = sel_q;
        sin_d     = sin_q;
        rx_data_d = rx_data_q;
        if (state_d == CSETUP) sel_d = 1'b1;
        if (state_d == SETUP) begin
            sel_d = 1'b0;
            sin_d = tx_sr_d[CHAIN_LEN-1];
        end
        if (state_d == FIN) rx_data_d = rx_sr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            count_q   <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            ld_q      <= 1'b0;
            phi_q     <= 1'b0;
            phib_q    <= 1'b0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_q     <= 1'b0;
            sin_q     <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            ld_q      <= ld_d;
            phi_q     <= phi_d;
            phib_q    <= phib_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sel_q     <= sel_d;
            sin_q     <= sin_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign phi       = phi_q;
    assign phib      = phib_q;
    assign load      = load_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign scan_i0o1 = sel_q;
    assign scan_in   = sin_q;
    assign rx_data   = rx_data_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench for scan_chain_ctrl: an 8-cell and a 32-cell instance, each driving a
// master/slave chain model; expected results are queued at start and checked on done.
module tb_scan_chain_ctrl;

    typedef struct {
        int          start_cyc;
        int          exp_cyc;
        int          deadline;
        logic [31:0] exp_rx;
        logic [31:0] exp_cells;
        logic [31:0] exp_chip;
        int          exp_phi;
        int          exp_load;
        bit          ld;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mdl_clr;
    int   cyc = 0;

    // 8-cell instance
    logic       a_start, a_cap, a_ld;
    logic [7:0] a_tx, a_rx;
    logic       a_busy, a_done, a_phi, a_phib, a_sel, a_load, a_sin, a_sout;
    logic [7:0] a_m, a_s, a_chip_out, a_chip_in;

    // 32-cell instance
    logic        b_start, b_cap, b_ld;
    logic [31:0] b_tx, b_rx;
    logic        b_busy, b_done, b_phi, b_phib, b_sel, b_load, b_sin, b_sout;
    logic [31:0] b_m, b_s;

    item_t qa[$];
    item_t qb[$];
    int    qr[$];
    item_t ia, ib;
    int    rt;

    int n_checks = 0;
    int n_fail   = 0;

    int   a_phi_hi, a_phib_hi, a_load_hi;
    logic a_viol, a_pphi, a_pphib, a_psel, a_psin;
    int   b_phi_hi, b_phib_hi, b_load_hi;
    logic b_viol, b_pphi, b_pphib, b_psel, b_psin;

    scan_chain_ctrl #(.CHAIN_LEN(8), .PW(2), .GAP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .capture_en(a_cap), .load_en(a_ld),
        .tx_data(a_tx), .busy(a_busy), .done(a_done), .rx_data(a_rx), .phi(a_phi),
        .phib(a_phib), .scan_i0o1(a_sel), .load(a_load), .scan_in(a_sin), .scan_out(a_sout)
    );

    scan_chain_ctrl #(.CHAIN_LEN(32), .PW(2), .GAP(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .capture_en(b_cap), .load_en(b_ld),
        .tx_data(b_tx), .busy(b_busy), .done(b_done), .rx_data(b_rx), .phi(b_phi),
        .phib(b_phib), .scan_i0o1(b_sel), .load(b_load), .scan_in(b_sin), .scan_out(b_sout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Chain models: phi loads masters (shift or capture), phib copies masters to slaves.
    always @(posedge a_phi or posedge mdl_clr)
        if (mdl_clr) a_m <= '0;
        else         a_m <= a_sel ? a_chip_out : {a_s[6:0], a_sin};
    always @(posedge a_phib or posedge mdl_clr)
        if (mdl_clr) a_s <= '0;
        else         a_s <= a_m;
    always @(posedge a_load or posedge mdl_clr)
        if (mdl_clr) a_chip_in <= '0;
        else         a_chip_in <= a_s;
    assign a_sout = a_s[7];

    always @(posedge b_phi or posedge mdl_clr)
        if (mdl_clr) b_m <= '0;
        else         b_m <= b_sel ? '0 : {b_s[30:0], b_sin};
    always @(posedge b_phib or posedge mdl_clr)
        if (mdl_clr) b_s <= '0;
        else         b_s <= b_m;
    assign b_sout = b_s[31];

    // Per-transaction pulse statistics and phase-rule tracking; cleared whenever idle.
    always @(negedge clk) begin
        a_pphi <= a_phi; a_pphib <= a_phib; a_psel <= a_sel; a_psin <= a_sin;
        if (!a_busy && !a_done) begin
            a_phi_hi <= 0; a_phib_hi <= 0; a_load_hi <= 0; a_viol <= 1'b0;
        end else begin
            if (a_phi)  a_phi_hi  <= a_phi_hi + 1;
            if (a_phib) a_phib_hi <= a_phib_hi + 1;
            if (a_load) a_load_hi <= a_load_hi + 1;
            if ((a_phi && a_phib) || (a_phi && a_pphib) || (a_phib && a_pphi) ||
                ((a_phi || a_phib) && (a_sel !== a_psel || a_sin !== a_psin)))
                a_viol <= 1'b1;
        end
    end

    always @(negedge clk) begin
        b_pphi <= b_phi; b_pphib <= b_phib; b_psel <= b_sel; b_psin <= b_sin;
        if (!b_busy && !b_done) begin
            b_phi_hi <= 0; b_phib_hi <= 0; b_load_hi <= 0; b_viol <= 1'b0;
        end else begin
            if (b_phi)  b_phi_hi  <= b_phi_hi + 1;
            if (b_phib) b_phib_hi <= b_phib_hi + 1;
            if (b_load) b_load_hi <= b_load_hi + 1;
            if ((b_phi && b_phib) || (b_phi && b_pphib) || (b_phib && b_pphi) ||
                ((b_phi || b_phib) && (b_sel !== b_psel || b_sin !== b_psin)))
                b_viol <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever a DUT signals done, or when its deadline passes.
    always @(negedge clk) begin
        if (a_done) begin
            if (qa.size() == 0) chk("a_spurious_done", 32'(a_done), 32'd0);
            else begin
                ia = qa.pop_front();
                chk("a_rx_data", 32'(a_rx), ia.exp_rx);
                chk("a_latency", cyc - ia.start_cyc + 1, ia.exp_cyc);
                chk("a_busy_at_done", 32'(a_busy), 32'd0);
                chk("a_phi_cycles", a_phi_hi, ia.exp_phi);
                chk("a_phib_cycles", a_phib_hi, ia.exp_phi);
                chk("a_load_cycles", a_load_hi, ia.exp_load);
                chk("a_phase_rules", 32'(a_viol), 32'd0);
                chk("a_chain_cells", 32'(a_s), ia.exp_cells);
                if (ia.ld) chk("a_chip_in", 32'(a_chip_in), ia.exp_chip);
            end
        end else if (qa.size() > 0 && cyc > qa[0].deadline) begin
            ia = qa.pop_front();
            chk("a_done_timeout", 32'(a_done), 32'd1);
        end

        if (b_done) begin
            if (qb.size() == 0) chk("b_spurious_done", 32'(b_done), 32'd0);
            else begin
                ib = qb.pop_front();
                chk("b_rx_data", b_rx, ib.exp_rx);
                chk("b_latency", cyc - ib.start_cyc + 1, ib.exp_cyc);
                chk("b_busy_at_done", 32'(b_busy), 32'd0);
                chk("b_phi_cycles", b_phi_hi, ib.exp_phi);
                chk("b_phib_cycles", b_phib_hi, ib.exp_phi);
                chk("b_load_cycles", b_load_hi, ib.exp_load);
                chk("b_phase_rules", 32'(b_viol), 32'd0);
                chk("b_chain_cells", b_s, ib.exp_cells);
            end
        end else if (qb.size() > 0 && cyc > qb[0].deadline) begin
            ib = qb.pop_front();
            chk("b_done_timeout", 32'(b_done), 32'd1);
        end

        if (qr.size() > 0 && cyc >= qr[0]) begin
            rt = qr.pop_front();
            chk("rst_a_outputs", 32'({a_phi, a_phib, a_load, a_sel, a_sin, a_busy, a_done}), 32'd0);
            chk("rst_a_rx_data", 32'(a_rx), 32'd0);
            chk("rst_b_outputs", 32'({b_phi, b_phib, b_load, b_sel, b_sin, b_busy, b_done}), 32'd0);
            chk("rst_b_rx_data", b_rx, 32'd0);
        end
    end

    task automatic a_push(input logic [7:0] tx, input logic ld, input logic [7:0] exp_rx,
                          input int exp_cyc, input int exp_phi, input int exp_load);
        item_t it;
        it.start_cyc = cyc;
        it.exp_cyc   = exp_cyc;
        it.deadline  = cyc + exp_cyc + 20;
        it.exp_rx    = 32'(exp_rx);
        it.exp_cells = 32'(tx);
        it.exp_chip  = 32'(tx);
        it.exp_phi   = exp_phi;
        it.exp_load  = exp_load;
        it.ld        = ld;
        qa.push_back(it);
    endtask

    task automatic a_go(input logic [7:0] tx, input logic cap, input logic ld, input bit expect_done,
                        input logic [7:0] exp_rx, input int exp_cyc, input int exp_phi,
                        input int exp_load);
        @(negedge clk);
        a_tx = tx; a_cap = cap; a_ld = ld; a_start = 1'b1;
        if (expect_done) a_push(tx, ld, exp_rx, exp_cyc, exp_phi, exp_load);
        @(negedge clk);
        a_start = 1'b0; a_cap = 1'b0; a_ld = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (qa.size() == 0 && qb.size() == 0 && qr.size() == 0 && !a_busy && !b_busy) break;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        item_t bi;
        rst_n = 1'b0; mdl_clr = 1'b1;
        a_start = 1'b0; a_cap = 1'b0; a_ld = 1'b0; a_tx = '0; a_chip_out = '0;
        b_start = 1'b0; b_cap = 1'b0; b_ld = 1'b0; b_tx = '0;
        repeat (3) @(negedge clk);
        qr.push_back(cyc + 1);
        @(negedge clk);
        rst_n = 1'b1; mdl_clr = 1'b0;
        wait_drain();

        // Plain shift: rx = reset chain, cells take tx
        a_go(8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 58, 16, 0);
        wait_drain();

        // Capture pair first: rx = chip_out
        a_chip_out = 8'h3C;
        a_go(8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 65, 18, 0);
        wait_drain();

        // Load after shift
        a_go(8'h81, 1'b0, 1'b1, 1'b1, 8'h00, 62, 16, 2);
        wait_drain();

        // Start while busy is ignored; start in FIN ignored, start right after accepted
        a_go(8'hA5, 1'b0, 1'b0, 1'b1, 8'h81, 58, 16, 0);
        repeat (10) @(negedge clk);
        a_tx = 8'h00; a_cap = 1'b1; a_ld = 1'b1; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_cap = 1'b0; a_ld = 1'b0;
        for (int i = 0; i < 100 && !a_done; i++) @(negedge clk);
        a_tx = 8'hFF; a_start = 1'b1;
        @(negedge clk);
        a_push(8'hFF, 1'b0, 8'hA5, 58, 16, 0);
        @(negedge clk);
        a_start = 1'b0;
        wait_drain();

        // Reset during the phi pulse of bit 3 abandons the transaction
        a_chip_out = 8'h96;
        a_go(8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 0);
        repeat (23) @(negedge clk);
        rst_n = 1'b0;
        qr.push_back(cyc + 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain();

        // Fresh transaction after the abort
        a_go(8'hC3, 1'b1, 1'b0, 1'b1, 8'h96, 65, 18, 0);
        wait_drain();

        // Default-size chain, walking one
        @(negedge clk);
        b_tx = 32'h0000_0001; b_start = 1'b1;
        bi.start_cyc = cyc;
        bi.exp_cyc   = 226;
        bi.deadline  = cyc + 246;
        bi.exp_rx    = 32'h0000_0000;
        bi.exp_cells = 32'h0000_0001;
        bi.exp_chip  = 32'h0000_0000;
        bi.exp_phi   = 64;
        bi.exp_load  = 0;
        bi.ld        = 1'b0;
        qb.push_back(bi);
        @(negedge clk);
        b_start = 1'b0;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
